// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the IFU (read-only) and the
// LSU (read/write). One transaction in flight at a time, round-robin on
// contention, and a RESP-phase timeout that turns a hung memory into an
// error response instead of a silent stall.
module mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    // IFU port
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_resp_err,
    // LSU port
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_resp_err,
    // memory port
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Grant encoding: 0 = IFU, 1 = LSU.
    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             wen_q, wen_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wmask_q, wmask_d;

    logic ifu_win;
    logic lsu_win;
    logic in_idle;
    logic in_resp;
    logic timeout_hit;
    logic resp_fire;
    logic resp_err;
    logic [31:0] resp_data;

    // Arbitration and upstream handshakes; reset suppresses every strobe so a
    // transaction cut by reset never reports anything.
    always_comb begin
        ifu_win     = ifu_req_valid && (!lsu_req_valid || (last_grant_q == GNT_LSU));
        lsu_win     = lsu_req_valid && (!ifu_req_valid || (last_grant_q == GNT_IFU));
        in_idle     = (state_q == IDLE) && !rst;
        in_resp     = (state_q == RESP) && !rst;
        timeout_hit = (cnt_q == CNT_LAST);
        // A real response in the timeout cycle takes priority over the error.
        resp_fire   = in_resp && (mem_resp_valid || timeout_hit);
        resp_err    = !mem_resp_valid;
        resp_data   = mem_resp_valid ? mem_rdata : 32'h0;

        ifu_req_ready  = in_idle && ifu_win;
        lsu_req_ready  = in_idle && lsu_win;

        ifu_resp_valid = resp_fire && (grant_q == GNT_IFU);
        ifu_rdata      = ifu_resp_valid ? resp_data : 32'h0;
        ifu_resp_err   = ifu_resp_valid && resp_err;

        lsu_resp_valid = resp_fire && (grant_q == GNT_LSU);
        lsu_rdata      = lsu_resp_valid ? resp_data : 32'h0;
        lsu_resp_err   = lsu_resp_valid && resp_err;

        mem_req_valid  = (state_q == REQ);
        mem_addr       = addr_q;
        mem_wen        = wen_q;
        mem_wdata      = wdata_q;
        mem_wmask      = wmask_q;
    end

    // Next-state logic for the IDLE -> REQ -> RESP transaction sequence.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;

        case (state_q)
            IDLE: begin
                if (lsu_win) begin
                    addr_d       = lsu_addr;
                    wen_d        = lsu_wen;
                    wdata_d      = lsu_wdata;
                    wmask_d      = lsu_wmask;
                    grant_d      = GNT_LSU;
                    last_grant_d = GNT_LSU;
                    state_d      = REQ;
                end else if (ifu_win) begin
                    addr_d       = ifu_addr;
                    wen_d        = 1'b0;
                    wdata_d      = 32'h0;
                    wmask_d      = 4'h0;
                    grant_d      = GNT_IFU;
                    last_grant_d = GNT_IFU;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_resp_valid || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= GNT_IFU;
            last_grant_q <= GNT_IFU;
            cnt_q        <= '0;
            addr_q       <= 32'h0;
            wen_q        <= 1'b0;
            wdata_q      <= 32'h0;
            wmask_q      <= 4'h0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: drives the two masters and plays the memory,
// pushing the expected response of every transaction into a queue that a
// negedge monitor pops when a response strobe appears.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        ifu_resp_err;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        is_lsu;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    mem_arbiter #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .ifu_resp_err   (ifu_resp_err),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .lsu_resp_err   (lsu_resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every response strobe must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check_eq("resp_in_reset", {31'h0, ifu_resp_valid | lsu_resp_valid}, 32'h0);
        end else begin
            if (ifu_req_ready || lsu_req_ready)
                check_eq("one_ready", {31'h0, ifu_req_ready & lsu_req_ready}, 32'h0);
            if (ifu_resp_valid || lsu_resp_valid) begin
                check_eq("one_resp", {31'h0, ifu_resp_valid & lsu_resp_valid}, 32'h0);
                check_eq("resp_expected", {31'h0, exp_q.size() != 0}, 32'h1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("resp_master", {31'h0, lsu_resp_valid}, {31'h0, e.is_lsu});
                    check_eq("resp_rdata", lsu_resp_valid ? lsu_rdata : ifu_rdata, e.data);
                    check_eq("resp_err", {31'h0, lsu_resp_valid ? lsu_resp_err : ifu_resp_err},
                             {31'h0, e.err});
                    check_eq("idle_master_quiet",
                             lsu_resp_valid ? (ifu_rdata | {31'h0, ifu_resp_err})
                                            : (lsu_rdata | {31'h0, lsu_resp_err}), 32'h0);
                    $display("[TB] resp %s rdata=0x%08h err=%0d", e.is_lsu ? "LSU" : "IFU",
                             lsu_resp_valid ? lsu_rdata : ifu_rdata,
                             lsu_resp_valid ? lsu_resp_err : ifu_resp_err);
                end
            end
        end
    end

    // Raise the requested masters, wait for a grant, check the winner.
    task automatic do_req(input logic use_ifu, input logic use_lsu, input logic [31:0] iaddr,
                          input logic [31:0] laddr, input logic lwen, input logic [31:0] lwdata,
                          input logic [3:0] lwmask, input logic exp_lsu);
        bit got = 0;
        ifu_req_valid = use_ifu;
        ifu_addr      = iaddr;
        lsu_req_valid = use_lsu;
        lsu_addr      = laddr;
        lsu_wen       = lwen;
        lsu_wdata     = lwdata;
        lsu_wmask     = lwmask;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifu_req_ready || lsu_req_ready) begin
                got = 1;
                break;
            end
        end
        check_eq("grant_seen", {31'h0, got}, 32'h1);
        check_eq("grant_winner", {31'h0, lsu_req_ready}, {31'h0, exp_lsu});
        $display("[TB] req granted to %s", lsu_req_ready ? "LSU" : "IFU");
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
    endtask

    // Act as the memory: hold off for ready_delay cycles, accept, then answer
    // after resp_delay silent RESP cycles.
    task automatic serve(input logic [31:0] e_addr, input logic e_wen, input logic [31:0] e_wdata,
                         input logic [3:0] e_wmask, input int ready_delay, input int resp_delay,
                         input logic [31:0] data, input logic is_lsu);
        exp_t e;
        for (int i = 0; i <= ready_delay; i++) begin
            if (i == ready_delay) mem_req_ready = 1'b1;
            @(negedge clk);
            check_eq("mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
            check_eq("mem_addr", mem_addr, e_addr);
            check_eq("mem_wen", {31'h0, mem_wen}, {31'h0, e_wen});
            check_eq("mem_wdata", mem_wdata, e_wdata);
            check_eq("mem_wmask", {28'h0, mem_wmask}, {28'h0, e_wmask});
            tick();
        end
        mem_req_ready = 1'b0;
        for (int i = 0; i < resp_delay; i++) begin
            @(negedge clk);
            check_eq("no_early_resp", {31'h0, ifu_resp_valid | lsu_resp_valid}, 32'h0);
            tick();
        end
        e.is_lsu = is_lsu;
        e.data   = data;
        e.err    = 1'b0;
        exp_q.push_back(e);
        mem_resp_valid = 1'b1;
        mem_rdata      = data;
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_mem_wmask_wen", {27'h0, mem_wmask, mem_wen}, 32'h0);
        check_eq("rst_outputs", {26'h0, ifu_req_ready, lsu_req_ready, ifu_resp_valid,
                 lsu_resp_valid, ifu_resp_err, lsu_resp_err}, 32'h0);
        tick();

        // Single IFU read, minimum latency.
        do_req(1, 0, 32'h8000_0000, 0, 0, 0, 0, 1'b0);
        serve(32'h8000_0000, 0, 0, 0, 0, 0, 32'h0010_0073, 1'b0);

        // Four contended transactions alternate, LSU first.
        for (int k = 0; k < 4; k++) begin
            logic el;
            el = (k % 2 == 0);
            do_req(1, 1, 32'h8000_0100 + 32'(k), 32'h8000_0200 + 32'(k), 0, 0, 0, el);
            serve(el ? 32'h8000_0200 + 32'(k) : 32'h8000_0100 + 32'(k), 0, 0, 0, 0, k,
                  32'hA000_0000 + 32'(k), el);
        end

        // LSU write held off by memory for 3 cycles.
        do_req(0, 1, 0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, 1'b1);
        serve(32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, 3, 1, 32'h1234_5678, 1'b1);

        // Timeout: no memory response, error in the 4th RESP cycle.
        do_req(1, 0, 32'h8000_2000, 0, 0, 0, 0, 1'b0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        e.is_lsu = 1'b0; e.data = 32'h0; e.err = 1'b1;
        exp_q.push_back(e);
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            check_eq("timeout_cycle", {31'h0, ifu_resp_valid}, {31'h0, c == TO});
            tick();
        end
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h5555_AAAA;
        @(negedge clk);
        check_eq("stray_resp_ignored", {31'h0, ifu_resp_valid | lsu_resp_valid}, 32'h0);
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;

        // Response arriving in the timeout cycle wins over the error.
        do_req(1, 0, 32'h8000_3000, 0, 0, 0, 0, 1'b0);
        serve(32'h8000_3000, 0, 0, 0, 0, TO - 1, 32'hCAFE_F00D, 1'b0);

        // Reset in RESP during an LSU transaction.
        do_req(0, 1, 0, 32'h8000_4000, 1, 32'h0BAD_F00D, 4'hF, 1'b1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h7777_7777;
        @(negedge clk);
        check_eq("post_rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
        check_eq("post_rst_mem_addr", mem_addr, 32'h0);
        check_eq("post_rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("post_rst_mem_wmask_wen", {27'h0, mem_wmask, mem_wen}, 32'h0);
        check_eq("post_rst_resp", {31'h0, ifu_resp_valid | lsu_resp_valid}, 32'h0);
        check_eq("post_rst_rdata", ifu_rdata | lsu_rdata, 32'h0);
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;

        // last_grant was reset to IFU, so the LSU wins this tie.
        do_req(1, 1, 32'h8000_5000, 32'h8000_6000, 0, 0, 0, 1'b1);
        serve(32'h8000_6000, 0, 0, 0, 0, 0, 32'h6666_0001, 1'b1);

        repeat (2) tick();
        check_eq("queue_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
